// File: rtl/amns_pkg.sv
// Shared definitions for the AMNS run controller: register map, bit positions and FSM states.
package amns_pkg;

    localparam logic [2:0] AddrCtrl    = 3'd0;
    localparam logic [2:0] AddrStatus  = 3'd1;
    localparam logic [2:0] AddrCycles  = 3'd2;
    localparam logic [2:0] AddrRuns    = 3'd3;
    localparam logic [2:0] AddrTimeout = 3'd4;

    localparam int unsigned CtrlGoBit    = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned CtrlAbortBit = 2;

    localparam int unsigned StatusBusyBit    = 0;
    localparam int unsigned StatusDoneBit    = 1;
    localparam int unsigned StatusTimeoutBit = 2;

    localparam int unsigned RstCyclesDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StAbort
    } run_state_e;

endpackage

// File: rtl/amns_sat_counter.sv
// Up-counter with synchronous clear and enable; optionally sticks at all-ones instead of wrapping.
module amns_sat_counter #(
    parameter int unsigned Width    = 32,
    parameter bit          Saturate = 1'b0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic at_max;

    assign at_max = &count_o;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (en_i && !(Saturate && at_max)) begin
            count_o <= count_o + Width'(1);
        end
    end

endmodule

// File: rtl/amns_run_ctrl.sv
// Run controller for the AMNS Montgomery multiplier: start pulse, latency measurement,
// optional timeout with core reset, and a level interrupt behind a small register bus.
module amns_run_ctrl
    import amns_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_CYCLES = RstCyclesDefault
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        wr_en_i,
    input  logic        rd_en_i,
    input  logic [2:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rd_valid_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        core_reset_o,
    output logic        busy_o,
    output logic        irq_o
);

    localparam int unsigned HoldW = $clog2(RST_CYCLES + 1);

    run_state_e       state_q, state_d;
    logic             done_q;
    logic             irq_en_q;
    logic             sticky_done_q;
    logic             sticky_timeout_q;
    logic [CNT_W-1:0] timeout_q;
    logic [CNT_W-1:0] cycles;
    logic [CNT_W-1:0] runs;
    logic [HoldW-1:0] hold_cnt;
    logic [31:0]      rd_mux;

    logic wr_ctrl, wr_status, go, abort_req;
    logic done_edge, timeout_hit, in_run;
    logic done_set, timeout_set;

    assign wr_ctrl   = wr_en_i && (addr_i == AddrCtrl);
    assign wr_status = wr_en_i && (addr_i == AddrStatus);
    assign go        = wr_ctrl && wdata_i[CtrlGoBit];
    assign abort_req = wr_ctrl && wdata_i[CtrlAbortBit];

    // Only the rising edge counts, so a done level left over from the last run is harmless.
    assign done_edge   = done_i && !done_q;
    assign in_run      = (state_q == StRun);
    assign timeout_hit = (timeout_q != '0) && (cycles == timeout_q);
    assign done_set    = in_run && done_edge;
    assign timeout_set = in_run && !done_edge && timeout_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (go) state_d = StStart;
            StStart: state_d = abort_req ? StAbort : StRun;
            StRun: begin
                if (done_edge) begin
                    state_d = StIdle;
                end else if (timeout_hit || abort_req) begin
                    state_d = StAbort;
                end
            end
            StAbort: if (hold_cnt == HoldW'(RST_CYCLES - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // CYCLES counts only RUN cycles that stay in RUN, so the exit cycle is never included.
    amns_sat_counter #(
        .Width    (CNT_W),
        .Saturate (1'b1)
    ) u_cycles (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (state_d == StStart),
        .en_i    (in_run && (state_d == StRun)),
        .count_o (cycles)
    );

    amns_sat_counter #(
        .Width    (CNT_W),
        .Saturate (1'b0)
    ) u_runs (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (1'b0),
        .en_i    (done_set),
        .count_o (runs)
    );

    amns_sat_counter #(
        .Width    (HoldW),
        .Saturate (1'b1)
    ) u_hold (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i ((state_d == StAbort) && (state_q != StAbort)),
        .en_i    (state_q == StAbort),
        .count_o (hold_cnt)
    );

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            AddrCtrl:    rd_mux[CtrlIrqEnBit] = irq_en_q;
            AddrStatus: begin
                rd_mux[StatusBusyBit]    = busy_o;
                rd_mux[StatusDoneBit]    = sticky_done_q;
                rd_mux[StatusTimeoutBit] = sticky_timeout_q;
            end
            AddrCycles:  rd_mux = 32'(cycles);
            AddrRuns:    rd_mux = 32'(runs);
            AddrTimeout: rd_mux = 32'(timeout_q);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q          <= StIdle;
            start_o          <= 1'b0;
            busy_o           <= 1'b0;
            core_reset_o     <= 1'b0;
            done_q           <= 1'b0;
            irq_en_q         <= 1'b0;
            sticky_done_q    <= 1'b0;
            sticky_timeout_q <= 1'b0;
            timeout_q        <= '0;
            rdata_o          <= '0;
            rd_valid_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_o      <= (state_d == StStart);
            busy_o       <= (state_d != StIdle);
            core_reset_o <= (state_d == StAbort);
            done_q       <= done_i;
            if (wr_ctrl) begin
                irq_en_q <= wdata_i[CtrlIrqEnBit];
            end
            if (wr_en_i && (addr_i == AddrTimeout)) begin
                timeout_q <= wdata_i[CNT_W-1:0];
            end
            // A set in the same cycle as its W1C wins.
            sticky_done_q <= done_set ||
                             (sticky_done_q && !(wr_status && wdata_i[StatusDoneBit]));
            sticky_timeout_q <= timeout_set ||
                                (sticky_timeout_q && !(wr_status && wdata_i[StatusTimeoutBit]));
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rdata_o <= rd_mux;
            end
        end
    end

    assign irq_o = irq_en_q && (sticky_done_q || sticky_timeout_q);

endmodule
